vga_pattern_gen: RTL and testbench
==================================

Name: vga_pattern_gen

Overview:
- Parametrised successor to the single-pattern display block. Sits between the VGA timing interface and the RGB output buffer.
- Keeps pixel X/Y counters for a configurable resolution and generates one of six test patterns, selected per frame.
- Adds a frame-end strobe, coordinate outputs, and a blank output during inactive periods.

Parameters:
- P_XY_W, 11, width of the X/Y coordinate counters.
- P_DISPLAY_X, 1024, active pixels per line (2 .. 2^P_XY_W).
- P_DISPLAY_Y, 768, active lines per frame (2 .. 2^P_XY_W).
- P_BAR_W, P_DISPLAY_X/8, width of one colour bar in pixels (>=1).
- P_CHK_LOG2, 5, log2 of the checkerboard cell size in pixels.
- P_SCROLL_STEP, 1, per-frame scroll increment (used only with the optional feature).

Ports:
- VGA_CLK, in, 1: pixel clock. All logic is on its rising edge.
- RST_N, in, 1: synchronous active-low reset, sampled on the rising edge of VGA_CLK.
- VGA_IF_RGBEN, in, 1: active-video enable from the timing generator.
- MODE, in, 3: requested pattern, sampled at the frame boundary.
- VGA_BUF_RGB, out, 24: pixel colour {R[7:0], G[7:0], B[7:0]}.
- CURRENT_X, out, P_XY_W: X counter value.
- CURRENT_Y, out, P_XY_W: Y counter value.
- MODE_ACTIVE, out, 3: pattern in use for the current frame.
- FRAME_END, out, 1: one-cycle pulse aligned with the last pixel of a frame on VGA_BUF_RGB.

Behaviour:
- Reset (RST_N=0 at a clock edge): all registers clear, including en_d, X, Y, bar counters, MODE_ACTIVE, VGA_BUF_RGB and FRAME_END. Reset takes priority over every other event. RST_N changing between edges has no effect.
- Enable pipeline: en_d <= VGA_IF_RGBEN each cycle. All counting and pixel generation is gated by en_d.
- Counters: on each cycle with en_d=1, X increments.
  - When X == P_DISPLAY_X-1, X wraps to 0 and Y increments.
  - When Y == P_DISPLAY_Y-1 at X wrap, Y wraps to 0.
  - With en_d=0, X and Y hold. Gaps of any length are legal mid-line.
- Mode selection: on an en_d=1 cycle, sel = (X==0 && Y==0) ? MODE : MODE_ACTIVE, and MODE_ACTIVE <= sel.
  - The first pixel of every frame uses the live MODE.
  - MODE changes mid-frame are ignored until the next (0,0).
- Bar tracking: bar_pix counts 0..P_BAR_W-1 on enabled cycles. On rollover, bar_idx increments and saturates at 7. Both clear when X wraps. bar_idx indexes the bars, so no divider is used.
- Pixel output: on an en_d=1 cycle, VGA_BUF_RGB <= pattern(sel, X, Y, bar_idx), using the pre-increment X and Y. With en_d=0, VGA_BUF_RGB <= 0.
- Latency: pixel (0,0) appears on VGA_BUF_RGB 2 cycles after VGA_IF_RGBEN first rises.
- Patterns:
  - 0 solid white: FFFFFF.
  - 1 colour bars: bar_idx 0..7 = FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000.
  - 2 checkerboard: X[P_CHK_LOG2] ^ Y[P_CHK_LOG2]. 0 gives FFFFFF, 1 gives 000000.
  - 3 horizontal grey ramp: R=G=B=X[7:0].
  - 4 vertical grey ramp: R=G=B=Y[7:0].
  - 5 border: FFFFFF when X==0, X==P_DISPLAY_X-1, Y==0 or Y==P_DISPLAY_Y-1; otherwise 000000.
  - 6 and 7 reserved: output 000000.
- FRAME_END <= 1 on the enabled cycle where X==P_DISPLAY_X-1 and Y==P_DISPLAY_Y-1; otherwise 0. It is high together with the last pixel of the frame on VGA_BUF_RGB.
- CURRENT_X and CURRENT_Y are the live counter registers. They lead VGA_BUF_RGB by 1 cycle.

Optional Feature:
- Macro: VGA_PATTERN_SCROLL_EN.
- When defined: a P_XY_W-bit scroll offset register is added, cleared by reset. It increments by P_SCROLL_STEP on every FRAME_END cycle and wraps modulo 2^P_XY_W. Patterns 2 and 3 use Xs = X + offset (truncated to P_XY_W bits) in place of X. All other modes, the counters and FRAME_END are unchanged.
- When undefined: the offset register is not built and all patterns use X directly.

Test Plan:
- Reset behaviour: RST_N=0 for 3 cycles with VGA_IF_RGBEN=1 -> VGA_BUF_RGB=0, CURRENT_X=CURRENT_Y=0, FRAME_END=0. RST_N rising to 1 -> first pixel appears on VGA_BUF_RGB 2 cycles after the first enabled edge.
- Colour bars: MODE=1, defaults, continuous enable -> pixel X=127 gives FFFFFF, X=128 gives FFFF00, X=640 gives FF0000, X=1023 gives 000000. Bars restart at FFFFFF on the next line.
- Small frame with gaps: P_DISPLAY_X=5, P_DISPLAY_Y=4, enable toggled 1/0 -> counters hold and RGB=0 during gaps; sequence (4,0)->(0,1), (4,3)->(0,0); FRAME_END is exactly one pulse per 20 enabled pixels.
- Mode change mid-frame: MODE switched from 2 to 3 at pixel (2,1) -> MODE_ACTIVE stays 2 to the frame end, then becomes 3 at (0,0); pixel (7,0) of the next frame = 070707.
- Checkerboard: MODE=2, P_CHK_LOG2=3 -> (0,0)=FFFFFF, (8,0)=000000, (8,8)=FFFFFF, (7,15)=000000.
- Reset mid-frame: RST_N=0 for one cycle at X=300, Y=10 -> all outputs 0 on the next edge; counting resumes from (0,0). With VGA_PATTERN_SCROLL_EN, MODE=3 -> after 2 frames, pixel (0,0) = 020202.

Source files
------------

// File: rtl/vga_pattern_gen.sv
// Pixel-coordinate tracker and per-frame test pattern generator for the VGA RGB path.
// Define VGA_PATTERN_SCROLL_EN to scroll the checkerboard and horizontal ramp by a per-frame offset.
module vga_pattern_gen #(
    parameter int P_XY_W      = 11,
    parameter int P_DISPLAY_X = 1024,
    parameter int P_DISPLAY_Y = 768,
    parameter int P_BAR_W     = P_DISPLAY_X / 8,
    parameter int P_CHK_LOG2  = 5
`ifdef VGA_PATTERN_SCROLL_EN
    ,
    parameter int P_SCROLL_STEP = 1
`endif
) (
    input  logic              VGA_CLK,
    input  logic              RST_N,
    input  logic              VGA_IF_RGBEN,
    input  logic [2:0]        MODE,
    output logic [23:0]       VGA_BUF_RGB,
    output logic [P_XY_W-1:0] CURRENT_X,
    output logic [P_XY_W-1:0] CURRENT_Y,
    output logic [2:0]        MODE_ACTIVE,
    output logic              FRAME_END
);

    typedef enum logic [2:0] {
        PAT_WHITE   = 3'd0,
        PAT_BARS    = 3'd1,
        PAT_CHECKER = 3'd2,
        PAT_HRAMP   = 3'd3,
        PAT_VRAMP   = 3'd4,
        PAT_BORDER  = 3'd5
    } pattern_e;

    localparam int                BAR_CW   = (P_BAR_W > 1) ? $clog2(P_BAR_W) : 1;
    localparam logic [P_XY_W-1:0] X_LAST   = P_XY_W'(P_DISPLAY_X - 1);
    localparam logic [P_XY_W-1:0] Y_LAST   = P_XY_W'(P_DISPLAY_Y - 1);
    localparam logic [BAR_CW-1:0] BAR_LAST = BAR_CW'(P_BAR_W - 1);

    logic              en_d;
    logic [P_XY_W-1:0] x_q;
    logic [P_XY_W-1:0] y_q;
    logic [P_XY_W-1:0] xs;
    logic [BAR_CW-1:0] bar_pix;
    logic [2:0]        bar_idx;
    logic              x_last;
    logic              y_last;
    logic [2:0]        sel;
    logic              chk;
    logic [7:0]        grey_x;
    logic [7:0]        grey_y;
    logic [23:0]       pix;

    assign CURRENT_X = x_q;
    assign CURRENT_Y = y_q;

    assign x_last = (x_q == X_LAST);
    assign y_last = (y_q == Y_LAST);
    // The live MODE is honoured only on the first pixel of a frame.
    assign sel    = (x_q == '0 && y_q == '0) ? MODE : MODE_ACTIVE;
    assign chk    = 1'((xs ^ y_q) >> P_CHK_LOG2);
    assign grey_x = 8'(xs);
    assign grey_y = 8'(y_q);

`ifdef VGA_PATTERN_SCROLL_EN
    logic [P_XY_W-1:0] scroll_off;

    always_ff @(posedge VGA_CLK) begin
        if (!RST_N) begin
            scroll_off <= '0;
        end else if (en_d && x_last && y_last) begin
            scroll_off <= scroll_off + P_XY_W'(P_SCROLL_STEP);
        end
    end

    assign xs = x_q + scroll_off;
`else
    assign xs = x_q;
`endif

    always_comb begin
        // NOTE: pix gets a default before the case so no path can leave it unassigned (no latch).
        pix = 24'h000000;
        case (sel)
            PAT_WHITE:   pix = 24'hFFFFFF;
            PAT_BARS: begin
                case (bar_idx)
                    3'd0: pix = 24'hFFFFFF;
                    3'd1: pix = 24'hFFFF00;
                    3'd2: pix = 24'h00FFFF;
                    3'd3: pix = 24'h00FF00;
                    3'd4: pix = 24'hFF00FF;
                    3'd5: pix = 24'hFF0000;
                    3'd6: pix = 24'h0000FF;
                    3'd7: pix = 24'h000000;
                endcase
            end
            PAT_CHECKER: pix = chk ? 24'h000000 : 24'hFFFFFF;
            PAT_HRAMP:   pix = {grey_x, grey_x, grey_x};
            PAT_VRAMP:   pix = {grey_y, grey_y, grey_y};
            PAT_BORDER:  pix = (x_q == '0 || x_last || y_q == '0 || y_last) ? 24'hFFFFFF : 24'h000000;
            default:     pix = 24'h000000;
        endcase
    end

    always_ff @(posedge VGA_CLK) begin
        // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
        if (!RST_N) begin
            en_d        <= 1'b0;
            x_q         <= '0;
            y_q         <= '0;
            bar_pix     <= '0;
            bar_idx     <= '0;
            MODE_ACTIVE <= '0;
            VGA_BUF_RGB <= '0;
            FRAME_END   <= 1'b0;
        end else begin
            en_d        <= VGA_IF_RGBEN;
            VGA_BUF_RGB <= '0;
            FRAME_END   <= 1'b0;
            if (en_d) begin
                MODE_ACTIVE <= sel;
                VGA_BUF_RGB <= pix;
                FRAME_END   <= x_last && y_last;
                if (x_last) begin
                    x_q     <= '0;
                    y_q     <= y_last ? '0 : y_q + 1'b1;
                    bar_pix <= '0;
                    bar_idx <= '0;
                end else begin
                    x_q <= x_q + 1'b1;
                    // Bar index advances every P_BAR_W pixels, avoiding a divider on X.
                    if (bar_pix == BAR_LAST) begin
                        bar_pix <= '0;
                        if (bar_idx != 3'd7) begin
                            bar_idx <= bar_idx + 3'd1;
                        end
                    end else begin
                        bar_pix <= bar_pix + 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Scoreboard bench for vga_pattern_gen: three instances (full-size, 16x16, 5x4) share clock
// and reset; a behavioural model pushes expected outputs per edge which are popped and compared.
module tb_vga_pattern_gen;

    localparam int XW = 11;

    typedef struct {
        logic [23:0]   rgb;
        logic          fe;
        logic [XW-1:0] cx;
        logic [XW-1:0] cy;
        logic [2:0]    ma;
        int            px;
        int            py;
    } exp_t;

    typedef struct {
        logic       en_d;
        int         x;
        int         y;
        logic [2:0] ma;
        int         off;
    } mdl_t;

    typedef struct {
        exp_t b;
        exp_t m;
        exp_t s;
    } exp3_t;

    logic clk;
    logic rst_n;
    logic en_b, en_m, en_s;
    logic [2:0] mode_b, mode_m, mode_s;
    logic [23:0] rgb_b, rgb_m, rgb_s;
    logic [XW-1:0] x_b, y_b, x_m, y_m, x_s, y_s;
    logic [2:0] ma_b, ma_m, ma_s;
    logic fe_b, fe_m, fe_s;

    exp3_t q[$];
    mdl_t  mb, mm, ms;
    int    tests = 0;
    int    failed = 0;

    logic [149:0] dut_vec;
    assign dut_vec = {rgb_b, fe_b, x_b, y_b, ma_b,
                      rgb_m, fe_m, x_m, y_m, ma_m,
                      rgb_s, fe_s, x_s, y_s, ma_s};

    vga_pattern_gen u_big (
        .VGA_CLK(clk), .RST_N(rst_n), .VGA_IF_RGBEN(en_b), .MODE(mode_b),
        .VGA_BUF_RGB(rgb_b), .CURRENT_X(x_b), .CURRENT_Y(y_b),
        .MODE_ACTIVE(ma_b), .FRAME_END(fe_b)
    );

    vga_pattern_gen #(.P_DISPLAY_X(16), .P_DISPLAY_Y(16), .P_BAR_W(2), .P_CHK_LOG2(3)) u_mid (
        .VGA_CLK(clk), .RST_N(rst_n), .VGA_IF_RGBEN(en_m), .MODE(mode_m),
        .VGA_BUF_RGB(rgb_m), .CURRENT_X(x_m), .CURRENT_Y(y_m),
        .MODE_ACTIVE(ma_m), .FRAME_END(fe_m)
    );

    vga_pattern_gen #(.P_DISPLAY_X(5), .P_DISPLAY_Y(4), .P_BAR_W(1)) u_small (
        .VGA_CLK(clk), .RST_N(rst_n), .VGA_IF_RGBEN(en_s), .MODE(mode_s),
        .VGA_BUF_RGB(rgb_s), .CURRENT_X(x_s), .CURRENT_Y(y_s),
        .MODE_ACTIVE(ma_s), .FRAME_END(fe_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [23:0] pattern(input logic [2:0] mode, input int x, input int y,
                                            input int dx, input int dy, input int barw,
                                            input int chk, input int off);
        logic [23:0] bars [8];
        logic [23:0] r;
        logic [7:0]  g;
        int xs;
        int idx;
        bars = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                 24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
        xs = (x + off) % 2048;
        r  = 24'h000000;
        case (mode)
            3'd0: r = 24'hFFFFFF;
            3'd1: begin
                idx = x / barw;
                if (idx > 7) idx = 7;
                r = bars[idx];
            end
            3'd2: r = ((((xs >> chk) ^ (y >> chk)) & 1) != 0) ? 24'h000000 : 24'hFFFFFF;
            3'd3: begin g = 8'(xs); r = {g, g, g}; end
            3'd4: begin g = 8'(y);  r = {g, g, g}; end
            3'd5: r = (x == 0 || x == dx - 1 || y == 0 || y == dy - 1) ? 24'hFFFFFF : 24'h000000;
            default: r = 24'h000000;
        endcase
        return r;
    endfunction

    task automatic model_step(input mdl_t si, input logic rst, input logic en, input logic [2:0] mode,
                              input int dx, input int dy, input int barw, input int chk,
                              output mdl_t so, output exp_t e);
        logic [2:0] sel;
        so    = si;
        e.rgb = 24'h000000;
        e.fe  = 1'b0;
        e.px  = -1;
        e.py  = -1;
        if (!rst) begin
            so.en_d = 1'b0;
            so.x    = 0;
            so.y    = 0;
            so.ma   = 3'd0;
            so.off  = 0;
        end else begin
            if (so.en_d) begin
                sel   = (so.x == 0 && so.y == 0) ? mode : so.ma;
                e.rgb = pattern(sel, so.x, so.y, dx, dy, barw, chk, so.off);
                e.fe  = (so.x == dx - 1 && so.y == dy - 1);
                e.px  = so.x;
                e.py  = so.y;
                so.ma = sel;
`ifdef VGA_PATTERN_SCROLL_EN
                if (e.fe) so.off = (so.off + 1) % 2048;
`endif
                if (so.x == dx - 1) begin
                    so.x = 0;
                    so.y = (so.y == dy - 1) ? 0 : so.y + 1;
                end else begin
                    so.x = so.x + 1;
                end
            end
            so.en_d = en;
        end
        e.cx = XW'(so.x);
        e.cy = XW'(so.y);
        e.ma = so.ma;
    endtask

    function automatic logic [49:0] pk(input exp_t e);
        return {e.rgb, e.fe, e.cx, e.cy, e.ma};
    endfunction

    function automatic logic [149:0] expv(input exp3_t e3);
        return {pk(e3.b), pk(e3.m), pk(e3.s)};
    endfunction

    // Drive one cycle of stimulus, push the model's expectation, advance past the edge.
    task automatic drive(input logic rst, input logic eb, input logic [2:0] mdb,
                         input logic em, input logic [2:0] mdm,
                         input logic es, input logic [2:0] mds);
        exp3_t e3;
        mdl_t  n;
        rst_n  = rst;
        en_b   = eb;  mode_b = mdb;
        en_m   = em;  mode_m = mdm;
        en_s   = es;  mode_s = mds;
        model_step(mb, rst, eb, mdb, 1024, 768, 128, 5, n, e3.b); mb = n;
        model_step(mm, rst, em, mdm, 16, 16, 2, 3, n, e3.m);      mm = n;
        model_step(ms, rst, es, mds, 5, 4, 1, 5, n, e3.s);        ms = n;
        q.push_back(e3);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        exp3_t e3;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 3'd0, 1'b1, 3'd0, 1'b1, 3'd0);
            e3 = q.pop_front();
            tests++;
            if (dut_vec !== expv(e3)) begin
                failed++;
                $display("FAIL reset_hold t=%0t got=%h exp=%h", $time, dut_vec, expv(e3));
            end
        end
        tests++;
        if ({rgb_b, x_b, y_b, fe_b} !== '0) begin
            failed++;
            $display("FAIL reset_zero got=%h exp=0", {rgb_b, x_b, y_b, fe_b});
        end
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b1, 3'd0, 1'b1, 3'd0, 1'b1, 3'd0);
            e3 = q.pop_front();
            tests++;
            if (dut_vec !== expv(e3)) begin
                failed++;
                $display("FAIL reset_release t=%0t got=%h exp=%h", $time, dut_vec, expv(e3));
            end
            tests++;
            if (rgb_b !== ((i == 1) ? 24'hFFFFFF : 24'h000000)) begin
                failed++;
                $display("FAIL first_pixel_latency cycle=%0d got=%h exp=%h", i + 1, rgb_b,
                         (i == 1) ? 24'hFFFFFF : 24'h000000);
            end
        end
    endtask

    task automatic test_colour_bars;
        exp3_t e3;
        logic [23:0] c;
        logic known;
        drive(1'b0, 1'b0, 3'd1, 1'b0, 3'd0, 1'b0, 3'd0);
        void'(q.pop_front());
        for (int i = 0; i < 1024 + 260; i++) begin
            drive(1'b1, 1'b1, 3'd1, 1'b0, 3'd0, 1'b0, 3'd0);
            e3 = q.pop_front();
            tests++;
            if (dut_vec !== expv(e3)) begin
                failed++;
                $display("FAIL bars_stream t=%0t got=%h exp=%h", $time, dut_vec, expv(e3));
            end
            known = 1'b1;
            c = 24'h000000;
            case (e3.b.px)
                0, 127: c = 24'hFFFFFF;
                128:    c = 24'hFFFF00;
                640:    c = 24'hFF0000;
                1023:   c = 24'h000000;
                default: known = 1'b0;
            endcase
            if (known && (e3.b.py == 0 || e3.b.py == 1)) begin
                tests++;
                if (rgb_b !== c) begin
                    failed++;
                    $display("FAIL bar_at x=%0d y=%0d got=%h exp=%h", e3.b.px, e3.b.py, rgb_b, c);
                end
            end
        end
    endtask

    task automatic test_small_gaps;
        exp3_t e3;
        logic en;
        int npix = 0;
        int pulses = 0;
        drive(1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd5);
        void'(q.pop_front());
        for (int i = 0; i < 140; i++) begin
            en = (i % 2 == 0) && !(i >= 60 && i < 67);
            drive(1'b1, 1'b0, 3'd0, 1'b0, 3'd0, en, 3'd5);
            e3 = q.pop_front();
            tests++;
            if (dut_vec !== expv(e3)) begin
                failed++;
                $display("FAIL gaps_stream t=%0t got=%h exp=%h", $time, dut_vec, expv(e3));
            end
            if (e3.s.px >= 0) npix++;
            if (fe_s === 1'b1) pulses++;
            if (e3.s.px == 4 && e3.s.py == 0) begin
                tests++;
                if ({x_s, y_s} !== {11'd0, 11'd1}) begin
                    failed++;
                    $display("FAIL wrap_line got=(%0d,%0d) exp=(0,1)", x_s, y_s);
                end
            end
            if (e3.s.px == 4 && e3.s.py == 3) begin
                tests++;
                if ({x_s, y_s, fe_s} !== {11'd0, 11'd0, 1'b1}) begin
                    failed++;
                    $display("FAIL wrap_frame got=(%0d,%0d,fe=%b) exp=(0,0,fe=1)", x_s, y_s, fe_s);
                end
            end
        end
        tests++;
        if (pulses != npix / 20) begin
            failed++;
            $display("FAIL frame_end_count got=%0d exp=%0d", pulses, npix / 20);
        end
    endtask

    task automatic test_mode_change;
        exp3_t e3;
        logic switched = 1'b0;
        logic [2:0] md;
        int frame = 0;
`ifdef VGA_PATTERN_SCROLL_EN
        logic [23:0] pix7 = 24'h080808;
`else
        logic [23:0] pix7 = 24'h070707;
`endif
        drive(1'b0, 1'b0, 3'd0, 1'b0, 3'd2, 1'b0, 3'd0);
        void'(q.pop_front());
        for (int i = 0; i < 2 * 256 + 4; i++) begin
            if (mm.en_d && mm.x == 2 && mm.y == 1) switched = 1'b1;
            md = switched ? 3'd3 : 3'd2;
            drive(1'b1, 1'b0, 3'd0, 1'b1, md, 1'b0, 3'd0);
            e3 = q.pop_front();
            tests++;
            if (dut_vec !== expv(e3)) begin
                failed++;
                $display("FAIL mode_stream t=%0t got=%h exp=%h", $time, dut_vec, expv(e3));
            end
            if (frame == 0 && ((e3.m.px == 2 && e3.m.py == 1) || (e3.m.px == 15 && e3.m.py == 15))) begin
                tests++;
                if (ma_m !== 3'd2) begin
                    failed++;
                    $display("FAIL mode_held x=%0d y=%0d got=%0d exp=2", e3.m.px, e3.m.py, ma_m);
                end
            end
            if (frame == 1 && e3.m.px == 0 && e3.m.py == 0) begin
                tests++;
                if (ma_m !== 3'd3) begin
                    failed++;
                    $display("FAIL mode_switch got=%0d exp=3", ma_m);
                end
            end
            if (frame == 1 && e3.m.px == 7 && e3.m.py == 0) begin
                tests++;
                if (rgb_m !== pix7) begin
                    failed++;
                    $display("FAIL ramp_pixel7 got=%h exp=%h", rgb_m, pix7);
                end
            end
            if (e3.m.fe) frame++;
        end
    endtask

    task automatic test_checkerboard;
        exp3_t e3;
        logic [23:0] c;
        logic known;
        drive(1'b0, 1'b0, 3'd0, 1'b0, 3'd2, 1'b0, 3'd0);
        void'(q.pop_front());
        for (int i = 0; i < 256 + 2; i++) begin
            drive(1'b1, 1'b0, 3'd0, 1'b1, 3'd2, 1'b0, 3'd0);
            e3 = q.pop_front();
            tests++;
            if (dut_vec !== expv(e3)) begin
                failed++;
                $display("FAIL checker_stream t=%0t got=%h exp=%h", $time, dut_vec, expv(e3));
            end
            known = 1'b1;
            c = 24'h000000;
            if      (e3.m.px == 0 && e3.m.py == 0)  c = 24'hFFFFFF;
            else if (e3.m.px == 8 && e3.m.py == 0)  c = 24'h000000;
            else if (e3.m.px == 8 && e3.m.py == 8)  c = 24'hFFFFFF;
            else if (e3.m.px == 7 && e3.m.py == 15) c = 24'h000000;
            else known = 1'b0;
            if (known) begin
                tests++;
                if (rgb_m !== c) begin
                    failed++;
                    $display("FAIL checker_at x=%0d y=%0d got=%h exp=%h", e3.m.px, e3.m.py, rgb_m, c);
                end
            end
        end
    endtask

    task automatic test_reset_mid_frame;
        exp3_t e3;
        int n = 0;
        drive(1'b0, 1'b0, 3'd5, 1'b0, 3'd0, 1'b0, 3'd0);
        void'(q.pop_front());
        while (!(mb.en_d && mb.x == 300 && mb.y == 10) && n < 20000) begin
            drive(1'b1, 1'b1, 3'd5, 1'b0, 3'd0, 1'b0, 3'd0);
            e3 = q.pop_front();
            tests++;
            if (dut_vec !== expv(e3)) begin
                failed++;
                $display("FAIL midrst_stream t=%0t got=%h exp=%h", $time, dut_vec, expv(e3));
            end
            n++;
        end
        if (n >= 20000) begin
            tests++;
            failed++;
            $display("FAIL midrst_timeout got=%0d cycles exp=<20000", n);
        end
        for (int i = 0; i < 3; i++) begin
            drive((i == 0) ? 1'b0 : 1'b1, 1'b1, 3'd5, 1'b0, 3'd0, 1'b0, 3'd0);
            e3 = q.pop_front();
            tests++;
            if (dut_vec !== expv(e3)) begin
                failed++;
                $display("FAIL midrst_resume t=%0t got=%h exp=%h", $time, dut_vec, expv(e3));
            end
        end
        tests++;
        if ({rgb_b, x_b, y_b} !== {24'hFFFFFF, 11'd1, 11'd0}) begin
            failed++;
            $display("FAIL midrst_restart got=%h,(%0d,%0d) exp=ffffff,(1,0)", rgb_b, x_b, y_b);
        end
    endtask

`ifdef VGA_PATTERN_SCROLL_EN
    task automatic test_scroll;
        exp3_t e3;
        int frame = 0;
        drive(1'b0, 1'b0, 3'd0, 1'b0, 3'd3, 1'b0, 3'd0);
        void'(q.pop_front());
        for (int i = 0; i < 2 * 256 + 4; i++) begin
            drive(1'b1, 1'b0, 3'd0, 1'b1, 3'd3, 1'b0, 3'd0);
            e3 = q.pop_front();
            tests++;
            if (dut_vec !== expv(e3)) begin
                failed++;
                $display("FAIL scroll_stream t=%0t got=%h exp=%h", $time, dut_vec, expv(e3));
            end
            if (frame == 2 && e3.m.px == 0 && e3.m.py == 0) begin
                tests++;
                if (rgb_m !== 24'h020202) begin
                    failed++;
                    $display("FAIL scroll_origin got=%h exp=020202", rgb_m);
                end
            end
            if (e3.m.fe) frame++;
        end
    endtask
`endif

    task automatic test_random;
        exp3_t e3;
        drive(1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0);
        void'(q.pop_front());
        for (int i = 0; i < 300; i++) begin
            drive(1'b1, 1'b0, 3'd0, 1'b0, 3'd0, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
            e3 = q.pop_front();
            tests++;
            if (dut_vec !== expv(e3)) begin
                failed++;
                $display("FAIL random_stream t=%0t got=%h exp=%h", $time, dut_vec, expv(e3));
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        en_b = 1'b0; en_m = 1'b0; en_s = 1'b0;
        mode_b = 3'd0; mode_m = 3'd0; mode_s = 3'd0;
        mb = '{1'b0, 0, 0, 3'd0, 0};
        mm = mb;
        ms = mb;
        #1;
        test_reset();
        test_colour_bars();
        test_small_gaps();
        test_mode_change();
        test_checkerboard();
        test_reset_mid_frame();
`ifdef VGA_PATTERN_SCROLL_EN
        test_scroll();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
